// File: rtl/conv3x3_serial_mac_if.sv
// ----------------------------------------------------------------------------
// conv3x3_serial_mac_if
// Bundles the window-input handshake, the tap-index/mux return path and the
// result handshake of the serial 3x3 MAC.
//
// Signals:
//   in_valid   upstream -> mac   window data/weights stable at mux inputs
//   in_ready   mac -> upstream   mac idle, able to accept a window
//   cnt        mac -> upstream   tap index 0..8 steering data/weight muxes
//   data_in    upstream -> mac   mux-selected pixel, unsigned
//   weight_in  upstream -> mac   mux-selected weight, two's complement
//   out_valid  mac -> downstream result available
//   out_ready  downstream -> mac result accepted
//   acc_out    mac -> downstream raw signed window sum
//   pix_out    mac -> downstream ReLU/shift/saturated pixel
//
// Modports: master = upstream/downstream side, slave = the MAC.
// ----------------------------------------------------------------------------
interface conv3x3_serial_mac_if #(
    parameter int ACC_W = 21
);
    logic                    in_valid;
    logic                    in_ready;
    logic [3:0]              cnt;
    logic [7:0]              data_in;
    logic [7:0]              weight_in;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] acc_out;
    logic [7:0]              pix_out;

    modport master (
        output in_valid, data_in, weight_in, out_ready,
        input  in_ready, cnt, out_valid, acc_out, pix_out
    );

    modport slave (
        input  in_valid, data_in, weight_in, out_ready,
        output in_ready, cnt, out_valid, acc_out, pix_out
    );
endinterface

// File: rtl/conv3x3_serial_mac.sv
// ----------------------------------------------------------------------------
// conv3x3_serial_mac
// Serial multiply-accumulate for one 3x3 convolution window. Steps the tap
// index cnt through 0..8, accumulates zext(pixel) * sext(weight) for each
// tap, then presents the raw sum and a ReLU/shift/saturated pixel through a
// valid/ready handshake.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   conv3x3_serial_mac_if.slave (see interface header)
//
// ACC_W must match the ACC_W of the connected interface instance.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | in_ready=1, waiting for in_valid; cnt=0
// RUN   | one tap per cycle, cnt 0..8; last tap registers the result
// DONE  | out_valid=1, result held until out_ready
// ----------------------------------------------------------------------------
module conv3x3_serial_mac #(
    parameter int ACC_W     = 21,
    parameter int OUT_SHIFT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    conv3x3_serial_mac_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_TAP = 4'd8;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_out_q;
    logic [7:0]              pix_q;
    logic                    out_valid_q;

    logic signed [16:0]      prod;
    logic signed [ACC_W-1:0] sum_next;
    logic signed [ACC_W-1:0] shifted;
    logic [7:0]              pix_next;

    // Pixel is zero-extended to 9 bits so the product is a true signed 9x8.
    assign prod     = $signed({1'b0, bus.data_in}) * $signed(bus.weight_in);
    assign sum_next = acc_q + {{(ACC_W-17){prod[16]}}, prod};
    assign shifted  = sum_next >>> OUT_SHIFT;

    always_comb begin
        pix_next = 8'd0;
        if (sum_next[ACC_W-1]) begin
            pix_next = 8'd0;
        end else if (shifted > ACC_W'(255)) begin
            pix_next = 8'hFF;
        end else begin
            pix_next = shifted[7:0];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.in_valid)       state_d = RUN;
            RUN:  if (cnt_q == LAST_TAP)  state_d = DONE;
            DONE: if (bus.out_ready)      state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= 4'd0;
            acc_q       <= '0;
            acc_out_q   <= '0;
            pix_q       <= 8'd0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        cnt_q <= 4'd0;
                        acc_q <= '0;
                    end
                end
                RUN: begin
                    acc_q <= sum_next;
                    if (cnt_q == LAST_TAP) begin
                        acc_out_q   <= sum_next;
                        pix_q       <= pix_next;
                        out_valid_q <= 1'b1;
                        cnt_q       <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    cnt_q       <= 4'd0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.cnt       = cnt_q;
    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc_out_q;
    assign bus.pix_out   = pix_q;

endmodule

// File: tb/tb_conv3x3_serial_mac.sv
module tb_conv3x3_serial_mac;

    localparam int ACC_W     = 21;
    localparam int OUT_SHIFT = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    conv3x3_serial_mac_if #(.ACC_W(ACC_W)) bus ();

    conv3x3_serial_mac #(.ACC_W(ACC_W), .OUT_SHIFT(OUT_SHIFT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] pix_a [9];
    logic [7:0] wt_a  [9];

    // Upstream 9:1 muxes steered by the DUT's tap index.
    always_comb begin
        bus.data_in   = 8'h00;
        bus.weight_in = 8'h00;
        for (int i = 0; i < 9; i++) begin
            if (int'(bus.cnt) == i) begin
                bus.data_in   = pix_a[i];
                bus.weight_in = wt_a[i];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain sum of the nine products, then ReLU/shift/clamp.
    function automatic int ref_sum();
        int s = 0;
        for (int k = 0; k < 9; k++) s += int'(pix_a[k]) * int'($signed(wt_a[k]));
        return s;
    endfunction

    function automatic int ref_pix(input int s);
        int v;
        if (s < 0) return 0;
        v = s >>> OUT_SHIFT;
        return (v > 255) ? 255 : v;
    endfunction

    task automatic load(input int pmode, input int pval, input int wval);
        for (int k = 0; k < 9; k++) begin
            pix_a[k] = (pmode == 1) ? 8'(k) : (pmode == 2) ? 8'($urandom_range(0, 255)) : 8'(pval);
            wt_a[k]  = (pmode == 2) ? 8'($urandom) : 8'(wval);
        end
    endtask

    function automatic logic [31:0] acc32();
        return 32'($signed(bus.acc_out));
    endfunction

    // Runs one window from IDLE; nbp>0 holds out_ready low for nbp cycles.
    task automatic window(input string tag, input int nbp);
        int es, ep;
        logic [31:0] held;
        int bad;
        es = ref_sum();
        ep = ref_pix(es);
        bus.in_valid  = 1'b1;
        bus.out_ready = (nbp == 0);
        step();
        bus.in_valid = 1'b0;
        chk({tag, "_in_ready_run"}, 32'(bus.in_ready), 0);
        bad = 0;
        for (int k = 0; k < 9; k++) begin
            if (int'(bus.cnt) != k || bus.out_valid !== 1'b0) bad++;
            step();
        end
        chk({tag, "_cnt_seq_errors"}, bad, 0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 1);
        chk({tag, "_acc_out"}, acc32(), es);
        chk({tag, "_pix_out"}, 32'(bus.pix_out), ep);
        chk({tag, "_cnt_done"}, 32'(bus.cnt), 0);
        if (nbp > 0) begin
            held = acc32();
            bad  = 0;
            for (int i = 0; i < nbp; i++) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                step();
                if (bus.out_valid !== 1'b1 || acc32() !== held || bus.in_ready !== 1'b0 ||
                    bus.cnt !== 4'd0 || 32'(bus.pix_out) !== 32'(ep)) bad++;
            end
            chk({tag, "_bp_stable_errors"}, bad, 0);
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        step();
        chk({tag, "_out_valid_drop"}, 32'(bus.out_valid), 0);
        chk({tag, "_in_ready_idle"}, 32'(bus.in_ready), 1);
    endtask

    initial begin
        int exp_q [$];
        int got, last_t, t, bad;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        load(0, 0, 0);

        rst = 1'b1;
        step();
        step();
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_cnt", 32'(bus.cnt), 0);
        chk("rst_acc_out", acc32(), 0);
        chk("rst_pix_out", 32'(bus.pix_out), 0);
        rst = 1'b0;
        step();

        load(0, 1, 1);       window("ones", 0);
        load(1, 0, 2);       window("ramp_w2", 0);
        load(0, 255, 1);     window("sat", 0);
        load(0, 255, 8'hFF); window("relu", 0);
        load(0, 255, 8'h80); window("min", 0);
        load(0, 255, 127);   window("max", 0);
        load(2, 0, 0);       window("rand_bp", 5);
        load(2, 0, 0);       window("rand", 0);

        // Reset mid-RUN at cnt==4.
        load(0, 7, 3);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (4) step();
        chk("abort_cnt_before", 32'(bus.cnt), 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_cnt", 32'(bus.cnt), 0);
        chk("abort_out_valid", 32'(bus.out_valid), 0);
        chk("abort_in_ready", 32'(bus.in_ready), 1);
        bad = 0;
        repeat (12) begin
            step();
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad++;
        end
        chk("abort_no_result", bad, 0);
        load(0, 1, 1);
        window("after_abort", 0);

        // Back-to-back windows, in_valid and out_ready held high.
        load(2, 0, 0);
        exp_q.push_back(ref_sum());
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        got    = 0;
        last_t = -1;
        bad    = 0;
        for (t = 0; t < 200 && got < 4; t++) begin
            step();
            if (bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    bad++;
                end else begin
                    if (acc32() !== 32'(exp_q[0])) bad++;
                    if (32'(bus.pix_out) !== 32'(ref_pix(exp_q[0]))) bad++;
                    void'(exp_q.pop_front());
                end
                if (last_t >= 0) chk("b2b_interval", t - last_t, 11);
                last_t = t;
                got++;
                if (got == 4) bus.in_valid = 1'b0;
            end
            if (bus.in_ready === 1'b1 && got < 4) begin
                load(2, 0, 0);
                exp_q.push_back(ref_sum());
            end
        end
        chk("b2b_results", got, 4);
        chk("b2b_value_errors", bad, 0);
        step();
        chk("b2b_final_idle", 32'(bus.in_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
